// File: rtl/scale_pkg.sv
// Shared types and fixed-point constants for the alpha scaling sequencer.
package scale_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned FRAC_BITS = 16;
    localparam int unsigned DATA_BITS = 16;
    localparam logic [15:0] ROUND_CONST = 16'h8000;

endpackage

// File: rtl/scale_mul16.sv
// Combinational Q8.8 (signed) x Q0.16 (unsigned) multiply, rescaled back to Q8.8.
// ALPHA_ROUND_EN selects round-half-up instead of floor truncation.
module scale_mul16
    import scale_pkg::*;
#(
    parameter int OUT_WIDTH = 32
) (
    input  logic [DATA_BITS-1:0] data,
    input  logic [DATA_BITS-1:0] scalar,
    output logic [OUT_WIDTH-1:0] result
);

    localparam int PROD_BITS = 2 * DATA_BITS + 1;

    logic signed [PROD_BITS-1:0] prod;
    logic signed [PROD_BITS-1:0] adj;
    logic signed [PROD_BITS-1:0] shifted;

    // Zero-extending the scalar keeps it non-negative inside a signed multiply.
    assign prod = $signed(data) * $signed({1'b0, scalar});

`ifdef ALPHA_ROUND_EN
    assign adj = prod + $signed({{(PROD_BITS - DATA_BITS){1'b0}}, ROUND_CONST});
`else
    assign adj = prod;
`endif

    assign shifted = adj >>> FRAC_BITS;
    assign result  = OUT_WIDTH'(shifted);

endmodule

// File: rtl/scalar_vector_sequencer.sv
// Streams a job of Q8.8 elements through one alpha multiplier with valid/ready on both sides.
// Optional macro ALPHA_ROUND_EN switches the multiplier to round-half-up.
module scalar_vector_sequencer
    import scale_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LEN_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic [WIDTH-1:0]     cfg_scalar,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 done
);

    state_t                 state;
    logic [DATA_BITS-1:0]   scalar_q;
    logic [LEN_WIDTH-1:0]   remaining;
    logic [WIDTH-1:0]       result;
    logic                   in_fire;
    logic                   out_fire;
    logic                   unused_bits;

    assign unused_bits = ^{in_data[WIDTH-1:DATA_BITS], cfg_scalar[WIDTH-1:DATA_BITS]};

    scale_mul16 #(.OUT_WIDTH(WIDTH)) u_mul (
        .data   (in_data[DATA_BITS-1:0]),
        .scalar (scalar_q),
        .result (result)
    );

    assign busy     = (state != IDLE);
    assign in_ready = (state == RUN) && (remaining != '0) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            scalar_q  <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        scalar_q  <= cfg_scalar[DATA_BITS-1:0];
                        remaining <= cfg_len;
                        if (cfg_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // A new element overwrites the register in the same cycle the old one drains.
                    if (in_fire) begin
                        out_data  <= result;
                        out_valid <= 1'b1;
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
